icache_burst_bridge: RTL

- Sits directly downstream of the instruction cache line loader; turns its single line-refill command (address + log2 size, 32-byte lines) into a sequence of single-word reads on a simple pipelined instruction bus.
- Returns the bus read data to the cache as an in-order response stream, one word per beat.
- The cache response port has no ready signal, so the bridge never stalls responses.
- Outstanding reads are bounded so the bus slave's queue cannot overflow.

---
 rtl/icache_burst_bridge.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/icache_burst_bridge.sv
// ---------------------------------------------------------------------------
// icache_burst_bridge
//
// Turns a single instruction-cache line refill command (byte address plus
// log2 of the burst size) into a series of single-word reads on a simple
// pipelined instruction bus. Read data comes back to the cache as an
// in-order response stream, one word per beat, with no backpressure.
// The number of bus reads in flight is capped at MAX_PENDING so that the
// bus slave's request queue can never overflow.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   io_cache_cmd_*                 refill request from the cache (valid/ready)
//   io_cache_rsp_*                 response words to the cache (valid only)
//   io_bus_cmd_*                   single-word read requests (valid/ready)
//   io_bus_rsp_*                   read data from the bus, in issue order
//   io_busy                        high while a burst is in progress
// ---------------------------------------------------------------------------
module icache_burst_bridge #(
    parameter int MAX_PENDING = 4,
    parameter int BEAT_BYTES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_cache_cmd_valid,
    output logic        io_cache_cmd_ready,
    input  logic [31:0] io_cache_cmd_payload_address,
    input  logic [2:0]  io_cache_cmd_payload_size,
    output logic        io_cache_rsp_valid,
    output logic [31:0] io_cache_rsp_payload_data,
    output logic        io_cache_rsp_payload_error,
    output logic        io_bus_cmd_valid,
    input  logic        io_bus_cmd_ready,
    output logic [31:0] io_bus_cmd_payload_address,
    input  logic        io_bus_rsp_valid,
    input  logic [31:0] io_bus_rsp_payload_data,
    input  logic        io_bus_rsp_payload_error,
    output logic        io_busy
);

    localparam int PEND_W     = $clog2(MAX_PENDING + 1);
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [PEND_W-1:0] PEND_LIMIT = PEND_W'(MAX_PENDING);

    typedef enum logic {
        IDLE,
        BURST
    } StateT;

    StateT             state;
    StateT             nextState;
    logic [31:0]       base;
    logic [3:0]        beats;
    logic [3:0]        issued;
    logic [3:0]        received;
    logic [PEND_W-1:0] pending;

    logic              cmdFire;
    logic              busFire;
    logic              rspAccept;
    logic              lastRsp;
    logic [2:0]        effSize;
    logic [31:0]       lineBase;
    logic [3:0]        lineBeats;

    // Sizes below one word collapse to a single beat and sizes above a full
    // 32-byte line are clamped to the line, so the burst never exceeds 8 beats
    // and the base stays word aligned.
    always_comb begin
        effSize = io_cache_cmd_payload_size;
        if (io_cache_cmd_payload_size < 3'(BEAT_SHIFT)) begin
            effSize = 3'(BEAT_SHIFT);
        end else if (io_cache_cmd_payload_size > 3'd5) begin
            effSize = 3'd5;
        end
    end

    assign lineBase  = io_cache_cmd_payload_address & ~((32'd1 << effSize) - 32'd1);
    assign lineBeats = 4'(4'd1 << (effSize - 3'(BEAT_SHIFT)));

    // A bus response with nothing outstanding is stray (for example it belongs
    // to a burst that was killed by reset) and is silently dropped.
    assign cmdFire   = io_cache_cmd_valid && io_cache_cmd_ready;
    assign busFire   = io_bus_cmd_valid && io_bus_cmd_ready;
    assign rspAccept = io_bus_rsp_valid && (pending != '0);
    assign lastRsp   = (state == BURST) && rspAccept && ((received + 4'd1) == beats);

    assign io_bus_cmd_payload_address = base + (32'(issued) << BEAT_SHIFT);

    // State register for the refill FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and handshake outputs. The bus request is only raised while
    // words remain and the slave has room; since pending can only fall while
    // a request waits, a raised request stays up with a stable address.
    always_comb begin
        nextState          = state;
        io_cache_cmd_ready = 1'b0;
        io_bus_cmd_valid   = 1'b0;
        io_busy            = 1'b0;
        unique case (state)
            IDLE: begin
                io_cache_cmd_ready = 1'b1;
                if (io_cache_cmd_valid) begin
                    nextState = BURST;
                end
            end
            BURST: begin
                io_busy          = 1'b1;
                io_bus_cmd_valid = (issued < beats) && (pending < PEND_LIMIT);
                if (lastRsp) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Burst bookkeeping: latched line base and length, words issued and
    // answered, and the in-flight count used for the outstanding cap.
    always_ff @(posedge clk) begin
        if (reset) begin
            base     <= '0;
            beats    <= '0;
            issued   <= '0;
            received <= '0;
            pending  <= '0;
        end else begin
            if (cmdFire) begin
                base     <= lineBase;
                beats    <= lineBeats;
                issued   <= '0;
                received <= '0;
            end else begin
                if (busFire) begin
                    issued <= issued + 4'd1;
                end
                if (rspAccept && (state == BURST)) begin
                    received <= received + 4'd1;
                end
            end
            unique case ({busFire, rspAccept})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Registered response path: one cycle behind the bus. Data and error are
    // only updated on an accepted word so they hold while valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_cache_rsp_valid         <= 1'b0;
            io_cache_rsp_payload_data  <= '0;
            io_cache_rsp_payload_error <= 1'b0;
        end else begin
            io_cache_rsp_valid <= rspAccept;
            if (rspAccept) begin
                io_cache_rsp_payload_data  <= io_bus_rsp_payload_data;
                io_cache_rsp_payload_error <= io_bus_rsp_payload_error;
            end
        end
    end

endmodule
